// File: rtl/rng_reader_pkg.sv
// Shared widths and serializer state encoding for the TRNG word reader.
// Imported by rng_word_fifo and rng_word_reader.
package rng_reader_pkg;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  typedef enum logic {
    EMPTY     = 1'b0,
    HAVE_WORD = 1'b1
  } ser_state_e;

  // Byte idx of a word, MSB first.
  function automatic logic [BYTE_W-1:0] pick_byte(
    input logic [WORD_W-1:0] w,
    input logic [IDX_W-1:0]  i
  );
    logic [WORD_W-1:0] s;
    s = w << (BYTE_W * int'(i));
    return s[WORD_W-1 -: BYTE_W];
  endfunction
endpackage

// File: rtl/rng_word_fifo.sv
// Word FIFO for the TRNG reader; a push at full is accepted
// when a pop happens in the same cycle.
module rng_word_fifo
  import rng_reader_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [WORD_W-1:0] din,
  input  logic              pop,
  output logic [WORD_W-1:0] dout,
  output logic [LW-1:0]     level,
  output logic              full,
  output logic              empty
);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/rng_word_reader.sv
// TRNG word consumer: buffers 32-bit words, serves bytes MSB first on rd_req edges.
// Optional RNG_READER_PARITY_EN adds a byte_parity output.
module rng_word_reader
  import rng_reader_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SYNC_STAGES = 2,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  input  logic              rd_req,
  input  logic              clear_flags,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  output logic [LW-1:0]     fifo_level,
  output logic              overflow,
`ifdef RNG_READER_PARITY_EN
  output logic              underrun,
  output logic              byte_parity
`else
  output logic              underrun
`endif
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   strobe;

  ser_state_e        state;
  logic [WORD_W-1:0] cur_word;
  logic [IDX_W-1:0]  idx;
  logic              last_byte;

  logic              push_req;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_dout;
  logic              ovf_set;
  logic              unf_set;
  logic [BYTE_W-1:0] next_byte;

  rng_word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .din   (word_in),
    .pop   (pop),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign strobe    = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign push_req  = en & word_valid;
  assign last_byte = (idx == IDX_W'(BYTES_PER_WORD - 1));
  assign next_byte = pick_byte(cur_word, idx);

  // Load when idle, or refill on the last byte so reads stay gapless.
  always_comb begin
    pop = 1'b0;
    unique case (1'b1)
      (state == EMPTY):     pop = ~fifo_empty;
      (state == HAVE_WORD): pop = ~fifo_empty & strobe & last_byte;
      default:              pop = 1'b0;
    endcase
  end

  assign ovf_set = push_req & fifo_full & ~pop;
  assign unf_set = strobe & (state == EMPTY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rd_req};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      cur_word   <= '0;
      idx        <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      overflow   <= 1'b0;
      underrun   <= 1'b0;
`ifdef RNG_READER_PARITY_EN
      byte_parity <= 1'b0;
`endif
    end else begin
      overflow <= (overflow & ~clear_flags) | ovf_set;
      underrun <= (underrun & ~clear_flags) | unf_set;
      case (state)
        EMPTY: begin
          if (strobe) byte_valid <= 1'b0;
          if (!fifo_empty) begin
            cur_word <= fifo_dout;
            idx      <= '0;
            state    <= HAVE_WORD;
          end
        end
        HAVE_WORD: begin
          if (strobe) begin
            byte_out   <= next_byte;
            byte_valid <= 1'b1;
            idx        <= idx + IDX_W'(1);
`ifdef RNG_READER_PARITY_EN
            byte_parity <= ^next_byte;
`endif
            if (last_byte) begin
              if (!fifo_empty) begin
                cur_word <= fifo_dout;
                idx      <= '0;
              end else begin
                state <= EMPTY;
              end
            end
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule
